// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-port memory between the
// instruction-fetch requester (I) and the load/store requester (D).
// Each access is issued, waits MEM_LATENCY cycles, and then completes
// with a one-cycle done pulse. Round-robin on ties, I first after reset.

package risc_pkg;
    typedef enum logic [1:0] {
        DMEM_BYTE = 2'd0,
        DMEM_HALF = 2'd1,
        DMEM_WORD = 2'd2
    } op_dmem_size;
endpackage

// Protocol checker: a requester must hold req while it owns the memory,
// and the two done pulses never coincide.
module unified_mem_arbiter_chk (
    input logic clk,
    input logic res_n,
    input logic busy,
    input logic own_i,
    input logic own_d,
    input logic i_req,
    input logic d_req,
    input logic i_done,
    input logic d_done
);
    a_i_req_held: assert property (@(posedge clk) disable iff (!res_n) (busy && own_i) |-> i_req);
    a_d_req_held: assert property (@(posedge clk) disable iff (!res_n) (busy && own_d) |-> d_req);
    a_done_excl:  assert property (@(posedge clk) disable iff (!res_n) !(i_done && d_done));
endmodule

module unified_mem_arbiter
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  op_dmem_size           d_size,
    input  logic                  d_zero_ex,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_done,
    output logic                  m_req,
    output logic                  m_wen,
    output op_dmem_size           m_size,
    output logic                  m_zero_ex,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wdata,
    input  logic [31:0]           m_rdata,
    output logic                  busy
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t      state, state_nxt;
    owner_t      owner, owner_nxt;
    owner_t      last_owner, last_owner_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        i_done_nxt, d_done_nxt, m_req_nxt;
    logic [31:0] i_rdata_nxt, d_rdata_nxt;
    logic        i_elig, d_elig, grant_i, grant_d;

    // A requester whose done is high this cycle still has req asserted; mask it
    // so the finished access is not granted a second time.
    assign i_elig  = i_req && !i_done;
    assign d_elig  = d_req && !d_done;
    assign grant_i = i_elig && (!d_elig || (last_owner == OWN_D));
    assign grant_d = d_elig && !grant_i;
    assign busy    = (state != IDLE);

    // Next-state, completion and response capture.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        i_done_nxt     = 1'b0;
        d_done_nxt     = 1'b0;
        m_req_nxt      = 1'b0;
        i_rdata_nxt    = i_rdata;
        d_rdata_nxt    = d_rdata;
        case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                if (grant_i) begin
                    owner_nxt = OWN_I;
                    state_nxt = ACCESS;
                    m_req_nxt = 1'b1;
                end else if (grant_d) begin
                    owner_nxt = OWN_D;
                    state_nxt = ACCESS;
                    m_req_nxt = 1'b1;
                end else begin
                    owner_nxt = OWN_NONE;
                end
            end
            ACCESS: begin
                if (cnt == LAT) begin
                    state_nxt      = IDLE;
                    owner_nxt      = OWN_NONE;
                    last_owner_nxt = owner;
                    cnt_nxt        = 4'd0;
                    if (owner == OWN_D) begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = m_rdata;
                    end else begin
                        i_done_nxt  = 1'b1;
                        i_rdata_nxt = m_rdata;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    // Memory-side attributes follow the current owner's inputs during ACCESS.
    always_comb begin
        m_wen     = 1'b0;
        m_size    = DMEM_WORD;
        m_zero_ex = 1'b0;
        m_addr    = '0;
        m_wdata   = 32'd0;
        if (state == ACCESS) begin
            if (owner == OWN_D) begin
                m_wen     = d_wr;
                m_size    = d_size;
                m_zero_ex = d_zero_ex;
                m_addr    = d_addr;
                m_wdata   = d_wdata;
            end else begin
                m_addr    = i_addr;
            end
        end else begin
            m_wen = 1'b0;
        end
    end

    // State register with synchronous active-low reset; reset aborts any access.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            last_owner <= OWN_D;
            cnt        <= 4'd0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
            m_req      <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cnt        <= cnt_nxt;
            i_done     <= i_done_nxt;
            d_done     <= d_done_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            m_req      <= m_req_nxt;
        end
    end

    unified_mem_arbiter_chk u_chk (
        .clk    (clk),
        .res_n  (res_n),
        .busy   (busy),
        .own_i  (owner == OWN_I),
        .own_d  (owner == OWN_D),
        .i_req  (i_req),
        .d_req  (d_req),
        .i_done (i_done),
        .d_done (d_done)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed scenarios plus randomized
// requesters, checked every cycle against a transaction-schedule model.
module tb_unified_mem_arbiter;
    import risc_pkg::*;

    localparam int AW  = 16;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        res_n;
    logic        i_req, d_req, d_wr, d_zero_ex;
    logic [15:0] i_addr, d_addr;
    logic [31:0] d_wdata;
    op_dmem_size d_size;
    logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic        i_done, d_done, m_req, m_wen, m_zero_ex, busy;
    op_dmem_size m_size;
    logic [15:0] m_addr;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .res_n(res_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_zero_ex(d_zero_ex),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_wen(m_wen), .m_size(m_size), .m_zero_ex(m_zero_ex),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
    );

    // ---------------- memories: device (driven by DUT) and reference ----------
    logic [7:0]  dev_mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        dev_init = 1'b0;
    logic [31:0] rd_lat = 32'd0;
    logic [31:0] dev_raw;

    function automatic logic [31:0] shape(logic [31:0] raw, op_dmem_size sz, logic zx);
        case (sz)
            DMEM_BYTE: return zx ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            DMEM_HALF: return zx ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default:   return raw;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(logic [15:0] a, op_dmem_size sz, logic zx);
        logic [31:0] raw;
        raw = {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
        return shape(raw, sz, zx);
    endfunction

    function automatic void ref_store(logic [15:0] a, op_dmem_size sz, logic [31:0] d);
        ref_mem[a] = d[7:0];
        if (sz != DMEM_BYTE) ref_mem[a + 16'd1] = d[15:8];
        if (sz == DMEM_WORD) begin
            ref_mem[a + 16'd2] = d[23:16];
            ref_mem[a + 16'd3] = d[31:24];
        end
    endfunction

    assign dev_raw = {dev_mem[m_addr + 16'd3], dev_mem[m_addr + 16'd2],
                      dev_mem[m_addr + 16'd1], dev_mem[m_addr]};
    assign m_rdata = (LAT == 0) ? shape(dev_raw, m_size, m_zero_ex) : rd_lat;

    // Memory device: copies the initial image once, then writes/reads on m_req.
    always @(posedge clk) begin
        if (!dev_init) begin
            for (int k = 0; k < 65536; k++) dev_mem[k] <= ref_mem[k];
            dev_init <= 1'b1;
        end else if (m_req) begin
            if (m_wen) begin
                dev_mem[m_addr] <= m_wdata[7:0];
                if (m_size != DMEM_BYTE) dev_mem[m_addr + 16'd1] <= m_wdata[15:8];
                if (m_size == DMEM_WORD) begin
                    dev_mem[m_addr + 16'd2] <= m_wdata[23:16];
                    dev_mem[m_addr + 16'd3] <= m_wdata[31:24];
                end
            end else begin
                rd_lat <= shape(dev_raw, m_size, m_zero_ex);
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- schedule model ----------------
    bit          act = 1'b0;
    int          g = 0, free_at = 0, last = 1;
    int          i_done_at = -1, d_done_at = -1;
    logic [31:0] pend = 32'd0, exp_i_rdata = 32'd0, exp_d_rdata = 32'd0;
    bit          d_known = 1'b1;
    logic [15:0] s_addr = 16'd0;
    logic        s_wen = 1'b0, s_zx = 1'b0;
    op_dmem_size s_size = DMEM_WORD;
    logic [31:0] s_wdata = 32'd0;
    int          done_log[$];
    logic        i_pd = 1'b0, d_pd = 1'b0;

    task automatic check_cycle();
        bit in_acc;
        if (i_done_at == cyc) exp_i_rdata = pend;
        if (d_done_at == cyc) begin
            exp_d_rdata = pend;
            d_known = !s_wen;
        end
        in_acc = act && (cyc >= g + 1) && (cyc <= g + 1 + LAT);
        chk("busy",    busy,    in_acc);
        chk("m_req",   m_req,   act && (cyc == g + 1));
        chk("i_done",  i_done,  cyc == i_done_at);
        chk("d_done",  d_done,  cyc == d_done_at);
        chk("i_rdata", i_rdata, exp_i_rdata);
        if (d_known) chk("d_rdata", d_rdata, exp_d_rdata);
        if (in_acc) begin
            chk("m_addr",    m_addr,    s_addr);
            chk("m_wen",     m_wen,     s_wen);
            chk("m_size",    m_size,    s_size);
            chk("m_zero_ex", m_zero_ex, s_zx);
            if (s_wen) chk("m_wdata", m_wdata, s_wdata);
        end else begin
            chk("m_wen_idle", m_wen, 1'b0);
        end
        if (i_done) done_log.push_back(0);
        if (d_done) done_log.push_back(1);
    endtask

    // Apply this cycle's inputs to the model (effect visible from next cycle).
    task automatic model_process();
        bit ie, de;
        if (!res_n) begin
            act = 1'b0; i_done_at = -1; d_done_at = -1;
            exp_i_rdata = 32'd0; exp_d_rdata = 32'd0; d_known = 1'b1;
            last = 1; free_at = cyc + 1;
            return;
        end
        if (cyc >= free_at) begin
            ie = i_req && (cyc != i_done_at);
            de = d_req && (cyc != d_done_at);
            if (ie || de) begin
                act = 1'b1; g = cyc; free_at = cyc + 2 + LAT;
                if (ie && (!de || last == 1)) begin
                    last = 0;
                    s_addr = i_addr; s_wen = 1'b0; s_size = DMEM_WORD; s_zx = 1'b0;
                    pend = ref_load(i_addr, DMEM_WORD, 1'b0);
                    i_done_at = cyc + 2 + LAT;
                end else begin
                    last = 1;
                    s_addr = d_addr; s_wen = d_wr; s_size = d_size; s_zx = d_zero_ex;
                    s_wdata = d_wdata;
                    if (d_wr) begin
                        ref_store(d_addr, d_size, d_wdata);
                        pend = 32'd0;
                    end else begin
                        pend = ref_load(d_addr, d_size, d_zero_ex);
                    end
                    d_done_at = cyc + 2 + LAT;
                end
            end
        end
    endtask

    task automatic tick();
        model_process();
        i_pd = i_done;
        d_pd = d_done;
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    task automatic wait_done(input bit is_d, input int t0, input int exp_lat, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (is_d ? d_done : i_done) seen = 1'b1;
            else tick();
        end
        chk(tag, seen ? (cyc - t0) : 9999, exp_lat);
    endtask

    task automatic new_d();
        d_wr      = 1'($urandom_range(0, 1));
        d_size    = op_dmem_size'($urandom_range(0, 2));
        d_zero_ex = 1'($urandom_range(0, 1));
        d_addr    = 16'($urandom);
        d_wdata   = $urandom;
    endtask

    // Requester agents: release/renew only the cycle after their own done.
    task automatic agents(input bit allow_new);
        if (i_req && i_pd) begin
            i_req = allow_new ? 1'($urandom_range(0, 1)) : 1'b0;
            i_addr = 16'($urandom);
        end else if (!i_req && allow_new && $urandom_range(0, 2) == 0) begin
            i_req = 1'b1; i_addr = 16'($urandom);
        end
        if (d_req && d_pd) begin
            d_req = allow_new ? 1'($urandom_range(0, 1)) : 1'b0;
            new_d();
        end else if (!d_req && allow_new && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; new_d();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (i_req || d_req || busy); k++) begin
            agents(1'b0);
            tick();
        end
        chk("drain_idle", {i_req, d_req, busy}, 3'b000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        for (int k = 0; k < 65536; k++) ref_mem[k] = 8'($urandom);
        {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'h0000_0013;
        {ref_mem[16'h0103], ref_mem[16'h0102], ref_mem[16'h0101], ref_mem[16'h0100]} = 32'hDEAD_BEEF;
        res_n = 1'b0; i_req = 1'b0; d_req = 1'b0; i_addr = 16'd0;
        d_wr = 1'b0; d_size = DMEM_WORD; d_zero_ex = 1'b0; d_addr = 16'd0; d_wdata = 32'd0;

        @(negedge clk);
        cyc = 0;
        check_cycle();
        tick();
        tick();
        res_n = 1'b1;
        tick();

        // I-only fetch of word 0x00000013
        i_req = 1'b1; i_addr = 16'h0000; t0 = cyc;
        wait_done(1'b0, t0, 2 + LAT, "i_only_lat");
        chk("i_only_data", i_rdata, 32'h0000_0013);
        tick(); i_req = 1'b0; tick();

        // Simultaneous requests right after reset: I first, then D
        res_n = 1'b0; tick(); res_n = 1'b1;
        i_req = 1'b1; i_addr = 16'h0000;
        d_req = 1'b1; d_wr = 1'b0; d_size = DMEM_WORD; d_zero_ex = 1'b0; d_addr = 16'h0100;
        t0 = cyc;
        wait_done(1'b0, t0, 2 + LAT, "tie_i_lat");
        tick(); i_req = 1'b0;
        wait_done(1'b1, t0, 2 * (2 + LAT), "tie_d_lat");
        chk("tie_d_data", d_rdata, 32'hDEAD_BEEF);
        tick(); d_req = 1'b0; tick();

        // Both held continuously: grants must alternate
        done_log.delete();
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        for (int k = 0; k < 200 && done_log.size() < 6; k++) tick();
        chk("alt_count", done_log.size() >= 6, 1'b1);
        for (int k = 0; k < 6 && k < done_log.size(); k++) chk("alt_order", done_log[k], k % 2);
        drain();

        // Store byte, then zero-extended byte load of the same address
        d_req = 1'b1; d_wr = 1'b1; d_size = DMEM_BYTE; d_zero_ex = 1'b0;
        d_addr = 16'h0203; d_wdata = 32'h0000_00AA; t0 = cyc;
        wait_done(1'b1, t0, 2 + LAT, "store_lat");
        tick(); d_req = 1'b0; tick();
        d_req = 1'b1; d_wr = 1'b0; d_zero_ex = 1'b1; t0 = cyc;
        wait_done(1'b1, t0, 2 + LAT, "ldb_lat");
        chk("ldb_data", d_rdata, 32'h0000_00AA);
        tick(); d_req = 1'b0; tick();

        // Reset during a D load access, then restart with d_req still high
        d_req = 1'b1; d_wr = 1'b0; d_size = DMEM_WORD; d_zero_ex = 1'b0; d_addr = 16'h0100;
        tick();
        res_n = 1'b0;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", d_done, 1'b0);
        res_n = 1'b1; t0 = cyc;
        wait_done(1'b1, t0, 2 + LAT, "rst_restart_lat");
        chk("rst_restart_data", d_rdata, 32'hDEAD_BEEF);
        tick(); d_req = 1'b0; tick();

        // Randomized traffic
        for (int k = 0; k < 2500; k++) begin
            agents(1'b1);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory (the `mem` instance) between the core's instruction-fetch requester (I) and its load/store requester (D).
- Sits between the fetch/LSU side of the core and the memory.
- Sequences each access as issue → wait for memory latency → registered response.
- Uses round-robin arbitration, so each requester stalls until its own done pulse.

Parameters:
- ADDR_WIDTH, 16, memory byte-address width.
- MEM_LATENCY, 1, cycles from m_req to valid m_rdata (0 = async read, max 15).

Ports:
- clk  input  1  clock
- res_n  input  1  reset, synchronous, active-low
- i_req  input  1  fetch request; held high with i_addr stable until i_done
- i_addr  input  ADDR_WIDTH  fetch address (always 32-bit read, zero_ex=0)
- i_rdata  output  32  fetched word, valid while i_done=1
- i_done  output  1  one-cycle completion pulse for I
- d_req  input  1  data request; held high with attributes stable until d_done
- d_wr  input  1  1=store, 0=load
- d_size  input  op_dmem_size  access size (risc_pkg)
- d_zero_ex  input  1  load zero-extend
- d_addr  input  ADDR_WIDTH  data address
- d_wdata  input  32  store data
- d_rdata  output  32  load data, valid while d_done=1
- d_done  output  1  one-cycle completion pulse for D
- m_req  output  1  memory request, one-cycle pulse per access
- m_wen  output  1  memory write enable
- m_size  output  op_dmem_size  memory access size
- m_zero_ex  output  1  memory zero-extend
- m_addr  output  ADDR_WIDTH  memory address
- m_wdata  output  32  memory write data
- m_rdata  input  32  memory read data
- busy  output  1  state != IDLE

Behaviour:
- All state is updated on posedge clk. res_n=0 at an edge forces, at that same edge:
  - state=IDLE, owner=none, last_owner=D, cnt=0
  - i_done=d_done=0, i_rdata=d_rdata=0, m_req=0
- Reset mid-access aborts the access. A store already pulsed on m_req is not undone. No done pulse is issued for an aborted access.
- States:
  - IDLE: arbitrate. If any eligible request, latch owner and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: m_req=1 in the first ACCESS cycle only; cnt counts ACCESS cycles from 0. When cnt==MEM_LATENCY, register m_rdata into the owner's rdata, set the owner's done=1 for the next cycle, update last_owner, and go to IDLE.
- Eligibility: a requester is masked from arbitration in the cycle its done=1, because its req is still high that cycle. This prevents a spurious regrant.
- Arbitration:
  - Only one requester eligible → grant it.
  - Both eligible → grant the one that is not last_owner.
  - After reset, I wins the first tie.
- m_* outputs:
  - In ACCESS they are driven from the owner's inputs.
  - I owner: m_wen=0, m_size=word, m_zero_ex=0.
  - D owner: m_wen=d_wr.
  - In IDLE, m_req=0 and m_wen=0; the other m_* fields are don't-care (X allowed under DEBUG).
- Latency: req first seen high in IDLE at cycle T → m_req at T+1 → done=1 and rdata valid at T+2+MEM_LATENCY.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Stores:
  - Same timing as loads; d_done signals completion.
  - d_rdata for a store is the registered m_rdata (don't-care).
  - The memory write occurs on the clk edge ending the m_req cycle.
- Done pulses last exactly one cycle. i_done and d_done are never high in the same cycle.
- rdata holds its last value when done=0.
- A req that drops before its done is a protocol violation (assertion). The arbiter still completes the access and pulses done.
- cnt is 4 bits, resets to 0 on IDLE entry, and never wraps, since MEM_LATENCY ≤ 15.

Test Plan:
- Reset, then I-only: i_addr=0x0000 with memory word 0x00000013, MEM_LATENCY=1 → m_req at T+1, i_done with i_rdata=0x00000013 at T+3; busy high T+1..T+2.
- Simultaneous i_req and d_req (load 0x0100 → 0xDEADBEEF) after reset → I served first (i_done at T+3), D next (m_req at T+4, d_done with d_rdata=0xDEADBEEF at T+6).
- Both held continuously for 6 accesses → grants alternate I,D,I,D,I,D; no done pulse within 1 cycle of the same requester's previous done.
- Store byte d_addr=0x0203, d_wdata=0x000000AA, then load byte with zero_ex=1 at 0x0203 → m_wen=1 only on the store's m_req; load returns 0x000000AA.
- MEM_LATENCY=0 and MEM_LATENCY=3 builds → done at T+2 and T+5 respectively; exactly one m_req per access.
- res_n=0 during ACCESS of a D load → next cycle busy=0, no d_done, m_req=0. After release with d_req still high → access restarts from IDLE and completes normally.
